vga_pos_writer: RTL
===================

// Module: vga_pos_writer
// PURPOSE
//  Write side of the sprite-position table that the VGA fetch counter reads.
//  Accepts a six-word position set from game logic through a start/ready handshake.
//  Snapshots the set, then writes it to memory slots BASE_ADDR+1..BASE_ADDR+6.
//  Slot order: 1 mx, 2 my, 3 p1x, 4 p1y, 5 p2x, 6 p2y, the same order the VGA reader fetches.
//  The memory port is shared, so the block requests it and writes only while granted.
// PARAMETERS
//  ADDR_W     16   width of mem_addr
//  BASE_ADDR  0    address of slot 0; slot n is written at BASE_ADDR+n
//  X_MAX      639  largest legal x coordinate (used only with BOUNDS_CLAMP_EN)
//  Y_MAX      479  largest legal y coordinate (used only with BOUNDS_CLAMP_EN)
// PORTS
//  clk       in   1       clock, all state changes on rising edge
//  reset     in   1       synchronous, active-low
//  start     in   1       request to write a new set; accepted only when ready=1
//  ready     out  1       1 = idle, start will be accepted this cycle
//  done      out  1       one-cycle pulse after slot 6 is written
//  mx_in     in   16      position words sampled when start is accepted
//  my_in     in   16      (as above)
//  p1x_in    in   16      (as above)
//  p1y_in    in   16      (as above)
//  p2x_in    in   16      (as above)
//  p2y_in    in   16      (as above)
//  mem_req   out  1       memory port request, high for the whole WRITE state
//  mem_gnt   in   1       memory port grant, may drop at any cycle
//  mem_we    out  1       write strobe = (state==WRITE) & mem_gnt
//  mem_addr  out  ADDR_W  BASE_ADDR + slot, truncated to ADDR_W
//  mem_data  out  16      snapshot word for the current slot
// BEHAVIOUR
//  - Reset (reset=0 at an edge) sets: state=IDLE, slot=1, snapshot=0.
//    Outputs in reset: ready=1, done=0, mem_req=0, mem_we=0, mem_addr=BASE_ADDR+1, mem_data=0.
//  - Reset mid-operation aborts at once: no further writes, and the partial table is left as is.
//  - IDLE: ready=1. At an edge with start=1, the six inputs are copied into the snapshot,
//    slot is set to 1 and the state moves to WRITE.
//  - WRITE: ready=0, mem_req=1. mem_addr and mem_data follow slot.
//    * In each cycle with mem_gnt=1, one word is written (mem_we=1) and slot increments at the edge.
//    * In a cycle with mem_gnt=0, mem_we=0 and slot holds; this pauses the sequence and nothing is lost.
//    * After the write of slot 6, the state moves to DONE and slot returns to 1.
//  - DONE: lasts one cycle. done=1, mem_req=0, mem_we=0; then the state moves to IDLE.
//  - start while WRITE or DONE is ignored, not queued. Input changes while busy have no effect.
//  - Latency with mem_gnt held high: start accepted at edge 0.
//    Writes occur in cycles 1..6, done=1 in cycle 7, ready=1 in cycle 8. Minimum period is 8 cycles.
//  - mem_we, mem_addr, mem_data and mem_req are decoded from registered state only.
//    There is no combinational path from start or the *_in inputs.
//  - No arithmetic on data beyond optional clamping; all words are unsigned 16-bit.
// CONFIGURATION
//  - BOUNDS_CLAMP_EN defined: at snapshot, clamp each word as unsigned.
//    * Slots 1, 3, 5 are x words: a value greater than X_MAX is stored as X_MAX.
//    * Slots 2, 4, 6 are y words: a value greater than Y_MAX is stored as Y_MAX.
//  - BOUNDS_CLAMP_EN undefined: words are stored and written unchanged, and X_MAX/Y_MAX are unused.
// TESTING
//  - Reset then idle: hold reset=0 for 2 cycles -> ready=1, mem_req=0, mem_we=0, done=0.
//  - Nominal write: BASE_ADDR=16'h0100, gnt=1, inputs 1,2,3,4,5,6, start 1 cycle
//    -> writes (0x0101,1) .. (0x0106,6) in cycles 1-6, done in cycle 7, ready in cycle 8.
//  - Grant stall: drop mem_gnt for 3 cycles after the slot-2 write
//    -> mem_we=0 and addr held at 0x0103 during the stall; writes resume at slot 3; done 3 cycles late.
//  - Busy start and input change: pulse start and set mx_in=16'hFFFF during WRITE
//    -> no restart, slot 1 keeps its snapshotted value, exactly 6 writes occur.
//  - Reset mid-op: assert reset after the slot-3 write
//    -> next cycle mem_we=0, mem_req=0, ready=1, and no slot-4 write occurs.
//  - Clamp (BOUNDS_CLAMP_EN): mx_in=1000, my_in=600, p1x_in=639
//    -> writes 639, 479, 639; without the macro -> writes 1000, 600, 639.

Source files
------------

// File: rtl/vga_pos_writer.sv
// ============================================================================
// Module   : vga_pos_writer
// Brief    : Snapshots a six-word sprite-position set and writes it to memory
//            slots BASE_ADDR+1..BASE_ADDR+6 over a shared, granted port.
//            Optional macro BOUNDS_CLAMP_EN clamps x/y words at snapshot.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_pos_writer #(
    parameter int              ADDR_W    = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter logic [15:0]     X_MAX     = 16'd639,
    parameter logic [15:0]     Y_MAX     = 16'd479
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              ready,
    output logic              done,
    input  logic [15:0]       mx_in,
    input  logic [15:0]       my_in,
    input  logic [15:0]       p1x_in,
    input  logic [15:0]       p1y_in,
    input  logic [15:0]       p2x_in,
    input  logic [15:0]       p2y_in,
    output logic              mem_req,
    input  logic              mem_gnt,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_data
);

`ifdef BOUNDS_CLAMP_EN
    localparam bit c_CLAMP_EN = 1'b1;
`else
    localparam bit c_CLAMP_EN = 1'b0;
`endif

    localparam logic [2:0] c_FIRST_SLOT = 3'd1;
    localparam logic [2:0] c_LAST_SLOT  = 3'd6;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic        w_load;
    logic        w_advance;
    logic [2:0]  r_slot;
    logic [15:0] r_mx;
    logic [15:0] r_my;
    logic [15:0] r_p1x;
    logic [15:0] r_p1y;
    logic [15:0] r_p2x;
    logic [15:0] r_p2y;

    // Unsigned saturation to a limit; a pass-through when clamping is disabled.
    function automatic logic [15:0] f_clamp(input logic [15:0] v, input logic [15:0] lim);
        return (c_CLAMP_EN && (v > lim)) ? lim : v;
    endfunction

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_advance    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_load       = 1'b1;
                    w_state_next = S_WRITE;
                end
            end
            S_WRITE: begin
                if (mem_gnt) begin
                    w_advance = 1'b1;
                    if (r_slot == c_LAST_SLOT) begin
                        w_state_next = S_DONE;
                    end
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Slot pointer and snapshot; the snapshot is only loaded from IDLE, so
    // input changes while busy never reach memory.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_slot <= c_FIRST_SLOT;
            r_mx   <= '0;
            r_my   <= '0;
            r_p1x  <= '0;
            r_p1y  <= '0;
            r_p2x  <= '0;
            r_p2y  <= '0;
        end else if (w_load) begin
            r_slot <= c_FIRST_SLOT;
            r_mx   <= f_clamp(mx_in,  X_MAX);
            r_my   <= f_clamp(my_in,  Y_MAX);
            r_p1x  <= f_clamp(p1x_in, X_MAX);
            r_p1y  <= f_clamp(p1y_in, Y_MAX);
            r_p2x  <= f_clamp(p2x_in, X_MAX);
            r_p2y  <= f_clamp(p2y_in, Y_MAX);
        end else if (w_advance) begin
            r_slot <= (r_slot == c_LAST_SLOT) ? c_FIRST_SLOT : r_slot + 3'd1;
        end
    end

    assign ready    = (r_state == S_IDLE);
    assign done     = (r_state == S_DONE);
    assign mem_req  = (r_state == S_WRITE);
    assign mem_we   = (r_state == S_WRITE) && mem_gnt;
    assign mem_addr = BASE_ADDR + ADDR_W'(r_slot);

    always_comb begin
        mem_data = '0;
        case (r_slot)
            3'd1:    mem_data = r_mx;
            3'd2:    mem_data = r_my;
            3'd3:    mem_data = r_p1x;
            3'd4:    mem_data = r_p1y;
            3'd5:    mem_data = r_p2x;
            3'd6:    mem_data = r_p2y;
            default: mem_data = '0;
        endcase
    end

endmodule

`default_nettype wire
